ntt_io_sched: RTL and testbench
===============================

# ntt_io_sched

Job sequencer that owns all data movement around the NTT core. It streams a job's coefficients into the 16-bank coefficient memory in interleaved order, then loads the twiddle-factor base and constant arrays into the TF generator, then starts the core and waits for its completion. After that it streams the result back out in natural order. It sits between the host-side valid/ready stream and `memory_top` / `TF_top` / the core controller, replacing backdoor preloading of the memory and TF arrays.

## Interface
- D_WIDTH, 17: coefficient / twiddle width (modulus 65537).
- BN, 16: number of memory banks.
- MA, 64: words per bank (degree = BN*MA = 1024).
- TF_COLS, 15: entries per TF base row.
- TF_ROWS, 9: TF base rows (k+3).
- TF_CONST, 14: TF constant entries.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  begin a job; honoured only in IDLE.
- in_data  in  D_WIDTH  load stream data.
- in_valid  in  1  load stream valid.
- in_ready  out  1  load stream ready.
- mem_we  out  1  coefficient memory write strobe.
- mem_wbank  out  log2(BN)  write bank.
- mem_waddr  out  log2(MA)  write address.
- mem_wdata  out  D_WIDTH  write data.
- mem_re  out  1  memory read strobe.
- mem_rbank  out  log2(BN)  read bank.
- mem_raddr  out  log2(MA)  read address.
- mem_rdata  in  D_WIDTH  read data, valid one cycle after mem_re.
- tf_we  out  1  TF array write strobe.
- tf_sel  out  1  0 = base array, 1 = const array.
- tf_row  out  4  base row (0 when tf_sel=1).
- tf_col  out  4  base column, or const index.
- tf_wdata  out  D_WIDTH  TF write data.
- core_start  out  1  one-cycle start pulse to the NTT core.
- core_done  in  1  core completion level/pulse.
- out_data  out  D_WIDTH  result stream data.
- out_valid  out  1  result stream valid.
- out_ready  in  1  result stream ready.
- busy  out  1  high in every state except IDLE.
- job_done  out  1  one-cycle pulse after the last result word is accepted.

## Operation
- States: IDLE → LD_COEF → LD_TFB → LD_TFC → RUN → UNLOAD → IDLE.
- IDLE: in_ready=0. cmd_start moves the FSM to LD_COEF and clears all counters.
- LD_COEF: in_ready=1. The n-th accepted word (n = 0..BN*MA-1) is written to bank n%BN, address n/BN. After word BN*MA-1 the FSM moves to LD_TFB.
- LD_TFB: the i-th word (i = 0..TF_ROWS*TF_COLS-1) is written with tf_sel=0, tf_row=i/TF_COLS, tf_col=i%TF_COLS. After the last word the FSM moves to LD_TFC.
- LD_TFC: the j-th word (j = 0..TF_CONST-1) is written with tf_sel=1, tf_col=j. After the last word the FSM moves to RUN.
- Bank/row/column indices come from wrapping counters (column/bank counters increment the row/address counter on wrap). No divider is used.
- RUN: in_ready=0. core_start pulses in the first RUN cycle. core_done sampled high in a later RUN cycle moves the FSM to UNLOAD. core_done is ignored in all other states and in the start cycle itself.
- UNLOAD: reads n = 0..BN*MA-1 from bank n%BN, address n/BN into a single output register. A read is issued only when the register will be free the next cycle (register empty, or out_valid&&out_ready this cycle). After the last word is accepted, job_done pulses and the FSM returns to IDLE.
- cmd_start outside IDLE is ignored. out_data is held stable while out_valid&&!out_ready.

## Timing
- Reset: state IDLE, all counters 0. Every output is 0 (in_ready, mem_we, mem_re, tf_we, core_start, out_valid, busy, job_done, and all address/data buses).
- Reset mid-job aborts immediately: no further writes, reads, or pulses. Partially loaded memory contents are not cleared.
- Write path is registered: a handshake in cycle t drives mem_we/tf_we with its address and data in cycle t+1. The last word of a phase is written one cycle after its handshake, while the next phase already accepts input.
- in_ready in LD_* states is independent of in_valid. Stall cycles (in_valid=0) produce no writes and no counter advance.
- busy rises in the cycle after cmd_start.
- Unload latency: the first mem_re is in the first UNLOAD cycle and the first out_valid follows 1 cycle later. With out_ready held at 1, throughput is one word per cycle (BN*MA+1 cycles of UNLOAD).
- job_done is asserted in the cycle after the final out handshake, coinciding with the return to IDLE.

## Test plan
- Load ramp 0..1023, then 135 TF base and 14 const words, with in_valid held high → word 17 written to bank 1/addr 1, word 1023 to bank 15/addr 63. TF word 16 lands at row 1/col 1, const word 13 at tf_sel=1/col 13. core_start pulses exactly once.
- Random in_valid gaps (~30% idle) → identical write sequence to the previous scenario. Total accepted words = 1173, then RUN.
- core_done pulsed during LD_TFB and in the core_start cycle → ignored. A later core_done moves the FSM to UNLOAD.
- Memory model returning the stored ramp, out_ready=1 → out_data 0,1,…,1023 on consecutive cycles. job_done pulses once, then busy=0.
- out_ready toggled randomly → no duplicated or dropped words. out_data holds stable while stalled.
- rst asserted mid-LD_COEF (word 300) → next cycle all outputs 0, state IDLE. A fresh cmd_start restarts with word 0 to bank 0/addr 0.

Source files
------------

// File: rtl/ntt_io_sched.sv
// Job sequencer around the NTT core: loads coefficients and TF tables from the
// host stream, starts the core, then streams the result back in natural order.
module ntt_io_sched #(
   parameter int D_WIDTH  = 17,
   parameter int BN       = 16,
   parameter int MA       = 64,
   parameter int TF_COLS  = 15,
   parameter int TF_ROWS  = 9,
   parameter int TF_CONST = 14,
   localparam int BW = $clog2(BN),
   localparam int AW = $clog2(MA)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_start,
   input  logic [D_WIDTH-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               mem_we,
   output logic [BW-1:0]      mem_wbank,
   output logic [AW-1:0]      mem_waddr,
   output logic [D_WIDTH-1:0] mem_wdata,
   output logic               mem_re,
   output logic [BW-1:0]      mem_rbank,
   output logic [AW-1:0]      mem_raddr,
   input  logic [D_WIDTH-1:0] mem_rdata,
   output logic               tf_we,
   output logic               tf_sel,
   output logic [3:0]         tf_row,
   output logic [3:0]         tf_col,
   output logic [D_WIDTH-1:0] tf_wdata,
   output logic               core_start,
   input  logic               core_done,
   output logic [D_WIDTH-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               job_done
);
   // state     | meaning
   // S_IDLE    | waiting for cmd_start
   // S_LD_COEF | coefficient stream -> interleaved memory writes
   // S_LD_TFB  | TF base array writes, row-major
   // S_LD_TFC  | TF constant array writes
   // S_RUN     | core started, waiting for core_done
   // S_UNLOAD  | natural-order readback into the output register
   typedef enum logic [2:0] {S_IDLE, S_LD_COEF, S_LD_TFB, S_LD_TFC, S_RUN, S_UNLOAD} state_t;

   localparam logic [BW-1:0] BANK_LAST  = BW'(BN - 1);
   localparam logic [AW-1:0] ADDR_LAST  = AW'(MA - 1);
   localparam logic [3:0]    COL_LAST   = 4'(TF_COLS - 1);
   localparam logic [3:0]    ROW_LAST   = 4'(TF_ROWS - 1);
   localparam logic [3:0]    CONST_LAST = 4'(TF_CONST - 1);

   state_t               state_q, state_d;
   logic [BW-1:0]        bank_q, bank_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [3:0]           row_idx_q, row_idx_d, col_idx_q, col_idx_d;
   logic                 rd_done_q, rd_done_d;
   logic                 in_ready_q, in_ready_d;
   logic                 mem_we_q, mem_we_d;
   logic [BW-1:0]        mem_wbank_q, mem_wbank_d;
   logic [AW-1:0]        mem_waddr_q, mem_waddr_d;
   logic [D_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                 tf_we_q, tf_we_d, tf_sel_q, tf_sel_d;
   logic [3:0]           tf_row_q, tf_row_d, tf_col_q, tf_col_d;
   logic [D_WIDTH-1:0]   tf_wdata_q, tf_wdata_d;
   logic                 core_start_q, core_start_d;
   logic                 out_valid_q, out_valid_d, out_fresh_q, out_fresh_d;
   logic [D_WIDTH-1:0]   out_hold_q, out_hold_d;
   logic                 busy_q, busy_d, job_done_q, job_done_d;
   logic                 in_hs, out_hs, rd_issue;

   // The output register is the memory's read register on the cycle after a
   // read, and a local hold copy thereafter while the consumer stalls.
   assign out_data  = out_fresh_q ? mem_rdata : out_hold_q;
   assign mem_re    = rd_issue;
   assign mem_rbank = (state_q == S_UNLOAD) ? bank_q : '0;
   assign mem_raddr = (state_q == S_UNLOAD) ? addr_q : '0;

   always_comb begin
      in_hs    = in_valid && in_ready_q;
      out_hs   = out_valid_q && out_ready;
      rd_issue = (state_q == S_UNLOAD) && !rd_done_q && (!out_valid_q || out_ready);

      state_d      = state_q;
      bank_d       = bank_q;
      addr_d       = addr_q;
      row_idx_d    = row_idx_q;
      col_idx_d    = col_idx_q;
      rd_done_d    = rd_done_q;
      mem_we_d     = 1'b0;
      mem_wbank_d  = mem_wbank_q;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      tf_we_d      = 1'b0;
      tf_sel_d     = tf_sel_q;
      tf_row_d     = tf_row_q;
      tf_col_d     = tf_col_q;
      tf_wdata_d   = tf_wdata_q;
      core_start_d = 1'b0;
      job_done_d   = 1'b0;
      out_valid_d  = out_valid_q;
      out_fresh_d  = 1'b0;
      out_hold_d   = out_data;

      case (state_q)
         S_IDLE: begin
            if (cmd_start) begin
               state_d   = S_LD_COEF;
               bank_d    = '0;
               addr_d    = '0;
               row_idx_d = '0;
               col_idx_d = '0;
               rd_done_d = 1'b0;
            end
         end
         S_LD_COEF: begin
            if (in_hs) begin
               mem_we_d    = 1'b1;
               mem_wbank_d = bank_q;
               mem_waddr_d = addr_q;
               mem_wdata_d = in_data;
               if (bank_q == BANK_LAST) begin
                  bank_d = '0;
                  if (addr_q == ADDR_LAST) begin
                     addr_d  = '0;
                     state_d = S_LD_TFB;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end else begin
                  bank_d = bank_q + 1'b1;
               end
            end
         end
         S_LD_TFB: begin
            if (in_hs) begin
               tf_we_d    = 1'b1;
               tf_sel_d   = 1'b0;
               tf_row_d   = row_idx_q;
               tf_col_d   = col_idx_q;
               tf_wdata_d = in_data;
               if (col_idx_q == COL_LAST) begin
                  col_idx_d = '0;
                  if (row_idx_q == ROW_LAST) begin
                     row_idx_d = '0;
                     state_d   = S_LD_TFC;
                  end else begin
                     row_idx_d = row_idx_q + 1'b1;
                  end
               end else begin
                  col_idx_d = col_idx_q + 1'b1;
               end
            end
         end
         S_LD_TFC: begin
            if (in_hs) begin
               tf_we_d    = 1'b1;
               tf_sel_d   = 1'b1;
               tf_row_d   = '0;
               tf_col_d   = col_idx_q;
               tf_wdata_d = in_data;
               if (col_idx_q == CONST_LAST) begin
                  col_idx_d    = '0;
                  state_d      = S_RUN;
                  core_start_d = 1'b1;
               end else begin
                  col_idx_d = col_idx_q + 1'b1;
               end
            end
         end
         S_RUN: begin
            // core_start_q marks the start cycle, where core_done is not trusted
            if (core_done && !core_start_q) state_d = S_UNLOAD;
         end
         S_UNLOAD: begin
            if (rd_issue) begin
               out_valid_d = 1'b1;
               out_fresh_d = 1'b1;
               if (bank_q == BANK_LAST) begin
                  bank_d = '0;
                  if (addr_q == ADDR_LAST) begin
                     addr_d    = '0;
                     rd_done_d = 1'b1;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end else begin
                  bank_d = bank_q + 1'b1;
               end
            end else if (out_hs) begin
               out_valid_d = 1'b0;
               if (rd_done_q) begin
                  state_d    = S_IDLE;
                  job_done_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d == S_LD_COEF) || (state_d == S_LD_TFB) || (state_d == S_LD_TFC);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bank_q       <= '0;
         addr_q       <= '0;
         row_idx_q    <= '0;
         col_idx_q    <= '0;
         rd_done_q    <= 1'b0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_wbank_q  <= '0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         tf_we_q      <= 1'b0;
         tf_sel_q     <= 1'b0;
         tf_row_q     <= '0;
         tf_col_q     <= '0;
         tf_wdata_q   <= '0;
         core_start_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_fresh_q  <= 1'b0;
         out_hold_q   <= '0;
         busy_q       <= 1'b0;
         job_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         addr_q       <= addr_d;
         row_idx_q    <= row_idx_d;
         col_idx_q    <= col_idx_d;
         rd_done_q    <= rd_done_d;
         in_ready_q   <= in_ready_d;
         mem_we_q     <= mem_we_d;
         mem_wbank_q  <= mem_wbank_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         tf_we_q      <= tf_we_d;
         tf_sel_q     <= tf_sel_d;
         tf_row_q     <= tf_row_d;
         tf_col_q     <= tf_col_d;
         tf_wdata_q   <= tf_wdata_d;
         core_start_q <= core_start_d;
         out_valid_q  <= out_valid_d;
         out_fresh_q  <= out_fresh_d;
         out_hold_q   <= out_hold_d;
         busy_q       <= busy_d;
         job_done_q   <= job_done_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_wbank  = mem_wbank_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign tf_we      = tf_we_q;
   assign tf_sel     = tf_sel_q;
   assign tf_row     = tf_row_q;
   assign tf_col     = tf_col_q;
   assign tf_wdata   = tf_wdata_q;
   assign core_start = core_start_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign job_done   = job_done_q;

endmodule

// File: tb/tb_ntt_io_sched.sv
// Scoreboard bench for ntt_io_sched: expected writes and results are queued at
// stimulus time and popped by monitors whenever the DUT presents them.
module tb_ntt_io_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_start = 1'b0;
   logic [16:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we, mem_re, tf_we, tf_sel, core_start, out_valid, busy, job_done;
   logic [3:0]  mem_wbank, mem_rbank, tf_row, tf_col;
   logic [5:0]  mem_waddr, mem_raddr;
   logic [16:0] mem_wdata, mem_rdata, tf_wdata, out_data;
   logic        core_done = 1'b0;
   logic        out_ready = 1'b1;

   ntt_io_sched dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_we(mem_we), .mem_wbank(mem_wbank), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_rbank(mem_rbank), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .tf_we(tf_we), .tf_sel(tf_sel), .tf_row(tf_row), .tf_col(tf_col), .tf_wdata(tf_wdata),
      .core_start(core_start), .core_done(core_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .job_done(job_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [26:0] exp_mem[$];
   logic [25:0] exp_tf[$];
   logic [16:0] exp_out[$];

   // coefficient memory model, one-cycle read latency
   logic [16:0] mem_arr [16][64];
   logic [16:0] rdata_q = '0;
   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_wbank][mem_waddr] <= mem_wdata;
      if (mem_re) rdata_q <= mem_arr[mem_rbank][mem_raddr];
   end
   assign mem_rdata = rdata_q;

   logic [26:0] e_mem;
   logic [25:0] e_tf;
   logic [16:0] e_out, stall_data;
   bit          stall_pend = 0;
   int          cs_count = 0;
   int          jd_count = 0;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_mem.size() == 0) check("mem_write_unexpected", {mem_wbank, mem_waddr, mem_wdata}, '1);
         else begin
            e_mem = exp_mem.pop_front();
            check("mem_write", {mem_wbank, mem_waddr, mem_wdata}, e_mem);
         end
      end
      if (tf_we === 1'b1) begin
         if (exp_tf.size() == 0) check("tf_write_unexpected", {tf_sel, tf_row, tf_col, tf_wdata}, '1);
         else begin
            e_tf = exp_tf.pop_front();
            check("tf_write", {tf_sel, tf_row, tf_col, tf_wdata}, e_tf);
         end
      end
      if (stall_pend) begin
         check("stall_valid_hold", out_valid, 1'b1);
         check("stall_data_hold", out_data, stall_data);
      end
      stall_pend = (out_valid === 1'b1) && !out_ready;
      stall_data = out_data;
      if (out_valid === 1'b1 && out_ready) begin
         if (exp_out.size() == 0) check("out_unexpected", out_data, '1);
         else begin
            e_out = exp_out.pop_front();
            check("out_data", out_data, e_out);
         end
      end
      if (core_start === 1'b1) cs_count++;
      if (job_done === 1'b1) jd_count++;
   end

   task automatic check_idle_zero(input string tag);
      check({tag, "_strobes"}, {in_ready, mem_we, mem_re, tf_we, core_start, out_valid, busy, job_done}, 0);
      check({tag, "_mem_bus"}, {mem_wbank, mem_waddr, mem_wdata, mem_rbank, mem_raddr}, 0);
      check({tag, "_tf_bus"}, {tf_sel, tf_row, tf_col, tf_wdata}, 0);
      check({tag, "_out_data"}, out_data, 0);
   endtask

   task automatic start_job();
      @(posedge clk); #1 cmd_start = 1'b1;
      @(negedge clk);
      check("busy_before_start", busy, 1'b0);
      @(posedge clk); #1 cmd_start = 1'b0;
      @(negedge clk);
      check("busy_rise", busy, 1'b1);
      check("in_ready_ld", in_ready, 1'b1);
      @(posedge clk); #1;
   endtask

   // entered and left at 1 time unit after a rising edge
   task automatic send_word(input logic [16:0] d, input bit gaps);
      int w;
      if (gaps) begin
         while ($urandom_range(99) < 30) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b1;
      in_data  = d;
      w = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (in_ready !== 1'b1) check("in_ready_timeout", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_job(input bit gaps, input bit rnd_ready, input int tf_base);
      logic [16:0] d;
      int cyc;
      cs_count = 0;
      jd_count = 0;
      out_ready = 1'b1;
      start_job();
      for (int n = 0; n < 1024; n++) begin
         d = gaps ? 17'((n * 7 + 11) % 65537) : 17'(n);
         if (n == 40) cmd_start = 1'b1;
         send_word(d, gaps);
         cmd_start = 1'b0;
         exp_mem.push_back({4'(n % 16), 6'(n / 16), d});
         exp_out.push_back(d);
      end
      for (int i = 0; i < 135; i++) begin
         d = 17'(tf_base + i);
         if (i == 5) core_done = 1'b1;
         send_word(d, gaps);
         core_done = 1'b0;
         exp_tf.push_back({1'b0, 4'(i / 15), 4'(i % 15), d});
      end
      for (int j = 0; j < 14; j++) begin
         d = 17'(tf_base + 500 + j);
         send_word(d, gaps);
         exp_tf.push_back({1'b1, 4'd0, 4'(j), d});
      end
      @(negedge clk);
      check("core_start_after_last", core_start, 1'b1);
      check("in_ready_run", in_ready, 1'b0);
      core_done = 1'b1;
      @(posedge clk); #1 core_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("core_done_ignored", {mem_re, out_valid, busy}, 3'b001);
      end
      @(posedge clk); #1 core_done = 1'b1;
      @(posedge clk); #1 core_done = 1'b0;
      @(negedge clk);
      check("unload_first_read", {mem_re, out_valid}, 2'b10);
      cyc = 0;
      while (job_done !== 1'b1 && cyc < 5000) begin
         @(posedge clk); #1 out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
         @(negedge clk);
         cyc++;
      end
      check("job_done_seen", job_done, 1'b1);
      if (!rnd_ready) check("unload_cycles", cyc, 1025);
      check("busy_at_done", busy, 1'b0);
      check("out_queue_empty", exp_out.size(), 0);
      check("mem_queue_empty", exp_mem.size(), 0);
      check("tf_queue_empty", exp_tf.size(), 0);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      check("job_done_single", {job_done, 32'(jd_count)}, {1'b0, 32'd1});
      check("core_start_once", cs_count, 1);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_zero("reset");

      run_job(1'b0, 1'b0, 2000);
      run_job(1'b1, 1'b1, 40000);

      // abort mid coefficient load
      start_job();
      for (int n = 0; n < 300; n++) begin
         send_word(17'(n + 500), 1'b0);
         exp_mem.push_back({4'(n % 16), 6'(n / 16), 17'(n + 500)});
      end
      in_valid = 1'b1;
      in_data  = 17'd800;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_idle_zero("rst_mid");
      check("rst_mid_writes", exp_mem.size(), 0);
      exp_out.delete();

      start_job();
      send_word(17'd77, 1'b0);
      exp_mem.push_back({4'd0, 6'd0, 17'd77});
      send_word(17'd78, 1'b0);
      exp_mem.push_back({4'd1, 6'd0, 17'd78});
      @(negedge clk);
      @(posedge clk); #1;
      check("restart_writes", exp_mem.size(), 0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_idle_zero("final_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
